// File: rtl/pwm_hbridge_driver.sv
// -----------------------------------------------------------------------------
// pwm_hbridge_driver
//
// Multi-channel PWM H-bridge driver. A single free-running counter sets the PWM
// period (2^CNT_W clocks) for all channels. Each channel decodes a one-hot speed
// command into a target duty, slews its applied duty toward that target by at
// most RAMP_STEP per period, and performs a drain / dead-time sequence before
// reversing direction, so the two bridge legs are never driven against each
// other.
//
// Ports
//   clk          : clock, all state on the rising edge
//   reset_in_n   : asynchronous active-low reset
//   en           : global enable; low gates all bridge outputs off
//   sw           : per-channel command, sw[8c+7] = direction,
//                  sw[8c+6:8c] = one-hot speed code
//   bridge       : per-channel registered drive, bridge[4c+3:4c]
//                  (4'b1001 forward, 4'b0110 reverse, 4'b0000 off)
//   busy         : per-channel, high while ramping, draining or in dead time
//   period_tick  : high for the clock in which the counter is all-ones
// -----------------------------------------------------------------------------
module pwm_hbridge_driver #(
  parameter int unsigned CNT_W     = 17,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned RAMP_STEP = 4096,
  parameter int unsigned DEAD_CYC  = 1024
) (
  input  logic                clk,
  input  logic                reset_in_n,
  input  logic                en,
  input  logic [NUM_CH*8-1:0] sw,
  output logic [NUM_CH*4-1:0] bridge,
  output logic [NUM_CH-1:0]   busy,
  output logic                period_tick
);

  // Duty carries one extra bit so a full-period value is representable.
  localparam int unsigned DW = CNT_W + 1;

  typedef logic [DW-1:0] duty_t;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StDead  = 2'd2
  } state_e;

  localparam duty_t       RampStep = duty_t'(RAMP_STEP);
  localparam logic [15:0] DeadInit = 16'(DEAD_CYC);

  localparam logic [3:0] DriveFwd = 4'b1001;
  localparam logic [3:0] DriveRev = 4'b0110;

  // floor((k+3) * 2^CNT_W / 10): 30% .. 90% of the period.
  function automatic duty_t pct_duty(input int unsigned k);
    logic [63:0] full;
    full = (64'(k) + 64'd3) << CNT_W;
    full = full / 64'd10;
    return full[DW-1:0];
  endfunction

  // Anything other than exactly one speed bit means stop.
  function automatic duty_t decode_speed(input logic [6:0] code);
    duty_t tgt;
    tgt = '0;
    if ($onehot(code)) begin
      for (int unsigned k = 0; k < 7; k++) begin
        if (code[k]) begin
          tgt = pct_duty(k);
        end
      end
    end
    return tgt;
  endfunction

  // ---------------------------------------------------------------------------
  // Shared period counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d       = cnt_q + CNT_W'(1);
  assign period_tick = &cnt_q;

  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel ramp, reversal FSM and output stage
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e      state_q, state_d;
    logic        dir_q, dir_d;
    duty_t       duty_q, duty_d;
    logic [15:0] dead_q, dead_d;
    logic [3:0]  bridge_q, bridge_d;
    logic        busy_q, busy_d;

    logic [7:0]  cmd;
    duty_t       tgt;
    duty_t       eff_q;
    duty_t       eff_d;
    duty_t       diff;

    assign cmd = sw[8*c +: 8];

    always_comb begin
      tgt      = decode_speed(cmd[6:0]);
      eff_q    = (state_q == StRun) ? tgt : '0;
      diff     = '0;
      duty_d   = duty_q;
      state_d  = state_q;
      dir_d    = dir_q;
      dead_d   = dead_q;
      eff_d    = '0;
      busy_d   = 1'b0;
      bridge_d = 4'b0000;

      // Slew toward the effective target once per period; the difference is
      // taken in the safe direction so neither add nor subtract can wrap.
      if (period_tick) begin
        if (eff_q > duty_q) begin
          diff   = eff_q - duty_q;
          duty_d = duty_q + ((diff > RampStep) ? RampStep : diff);
        end else begin
          diff   = duty_q - eff_q;
          duty_d = duty_q - ((diff > RampStep) ? RampStep : diff);
        end
      end

      case (state_q)
        StRun: begin
          if (cmd[7] != dir_q) begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (duty_q == '0) begin
            state_d = StDead;
            dead_d  = DeadInit;
          end
        end
        StDead: begin
          // Direction is sampled only here; a request that flipped back in the
          // meantime still gets the full dead time.
          dead_d = dead_q - 16'd1;
          if (dead_q == 16'd1) begin
            state_d = StRun;
            dir_d   = cmd[7];
          end
        end
        default: begin
          state_d = StRun;
        end
      endcase

      // Outputs are registered from next-state values so that bridge lines up
      // with the counter value visible in the same cycle.
      eff_d  = (state_d == StRun) ? tgt : '0;
      busy_d = (state_d != StRun) || (duty_d != eff_d);

      if (en && (state_d != StDead) && ({1'b0, cnt_d} < duty_d)) begin
        bridge_d = dir_d ? DriveFwd : DriveRev;
      end
    end

    always_ff @(posedge clk or negedge reset_in_n) begin
      if (!reset_in_n) begin
        state_q  <= StRun;
        dir_q    <= 1'b0;
        duty_q   <= '0;
        dead_q   <= '0;
        bridge_q <= 4'b0000;
        busy_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        dir_q    <= dir_d;
        duty_q   <= duty_d;
        dead_q   <= dead_d;
        bridge_q <= bridge_d;
        busy_q   <= busy_d;
      end
    end

    assign bridge[4*c +: 4] = bridge_q;
    assign busy[c]          = busy_q;
  end

endmodule

// File: tb/tb_pwm_hbridge_driver.sv
// -----------------------------------------------------------------------------
// tb_pwm_hbridge_driver
//
// Bench for pwm_hbridge_driver with CNT_W=8, NUM_CH=2, RAMP_STEP=64, DEAD_CYC=4.
// A cycle model predicts {bridge, busy, period_tick} for every clock; the
// prediction is queued when inputs are driven and compared after the edge.
// A table of per-period vectors checks the observed on-time and drive pattern
// of each channel against fixed duty values, and a hand-written sequence
// pulses reset in the middle of a dead-time window.
// -----------------------------------------------------------------------------
module tb_pwm_hbridge_driver;

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned NUM_CH    = 2;
  localparam int unsigned RAMP_STEP = 64;
  localparam int unsigned DEAD_CYC  = 4;

  localparam int Period = 256;
  localparam int Step   = 64;
  localparam int Dead   = 4;
  localparam int SRun   = 0;
  localparam int SDrain = 1;
  localparam int SDead  = 2;

  logic        clk = 1'b0;
  logic        reset_in_n;
  logic        en;
  logic [15:0] sw;
  logic [7:0]  bridge;
  logic [1:0]  busy;
  logic        period_tick;

  always #5 clk = ~clk;

  pwm_hbridge_driver #(
    .CNT_W    (CNT_W),
    .NUM_CH   (NUM_CH),
    .RAMP_STEP(RAMP_STEP),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk        (clk),
    .reset_in_n (reset_in_n),
    .en         (en),
    .sw         (sw),
    .bridge     (bridge),
    .busy       (busy),
    .period_tick(period_tick)
  );

  typedef struct {
    logic [7:0] bridge;
    logic [1:0] busy;
    logic       tick;
  } exp_t;

  typedef struct {
    logic [15:0] sw;
    logic        en;
    int          on0;
    int          on1;
    logic [3:0]  pat0;
    logic [3:0]  pat1;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[$];

  int checks;
  int failures;

  int   m_cnt;
  int   m_duty [2];
  int   m_st   [2];
  logic m_dir  [2];
  int   m_dead [2];

  int         on_cnt [2];
  logic [3:0] pat_or [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int tgt(input logic [7:0] cmd);
    case (cmd[6:0])
      7'h01:   return 76;
      7'h02:   return 102;
      7'h04:   return 128;
      7'h08:   return 153;
      7'h10:   return 179;
      7'h20:   return 204;
      7'h40:   return 230;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int c = 0; c < 2; c++) begin
      m_duty[c] = 0;
      m_st[c]   = SRun;
      m_dir[c]  = 1'b0;
      m_dead[c] = 0;
    end
    sbq.delete();
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step(output exp_t e);
    int         nduty [2];
    int         nst   [2];
    logic       ndir  [2];
    int         ndead [2];
    int         eff;
    int         gap;
    logic [7:0] cmd;
    for (int c = 0; c < 2; c++) begin
      cmd      = sw[8*c +: 8];
      eff      = (m_st[c] == SRun) ? tgt(cmd) : 0;
      nduty[c] = m_duty[c];
      nst[c]   = m_st[c];
      ndir[c]  = m_dir[c];
      ndead[c] = m_dead[c];
      if (m_cnt == Period - 1) begin
        gap = (eff > m_duty[c]) ? eff - m_duty[c] : m_duty[c] - eff;
        if (gap > Step) gap = Step;
        nduty[c] = (eff > m_duty[c]) ? m_duty[c] + gap : m_duty[c] - gap;
      end
      if (m_st[c] == SRun) begin
        if (cmd[7] != m_dir[c]) nst[c] = SDrain;
      end else if (m_st[c] == SDrain) begin
        if (m_duty[c] == 0) begin
          nst[c]   = SDead;
          ndead[c] = Dead;
        end
      end else begin
        ndead[c] = m_dead[c] - 1;
        if (m_dead[c] == 1) begin
          nst[c]  = SRun;
          ndir[c] = cmd[7];
        end
      end
    end
    m_cnt    = (m_cnt + 1) % Period;
    e.bridge = '0;
    e.busy   = '0;
    e.tick   = (m_cnt == Period - 1);
    for (int c = 0; c < 2; c++) begin
      m_duty[c] = nduty[c];
      m_st[c]   = nst[c];
      m_dir[c]  = ndir[c];
      m_dead[c] = ndead[c];
      cmd       = sw[8*c +: 8];
      if (en && m_st[c] != SDead && m_cnt < m_duty[c])
        e.bridge[4*c +: 4] = m_dir[c] ? 4'b1001 : 4'b0110;
      e.busy[c] = (m_st[c] != SRun) || (m_duty[c] != tgt(cmd));
    end
  endtask

  task automatic step();
    exp_t e;
    exp_t want;
    logic [3:0] nib;
    model_step(e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    want = sbq.pop_front();
    chk("cycle", 32'({bridge, busy, period_tick}), 32'({want.bridge, want.busy, want.tick}));
    for (int c = 0; c < 2; c++) begin
      nib = bridge[4*c +: 4];
      checks++;
      if (nib == 4'b1111 || nib == 4'b1100 || nib == 4'b0011) begin
        failures++;
        $display("FAIL illegal_pattern ch%0d: got %b required not 1111/1100/0011 at %0t",
                 c, nib, $time);
      end
      if (nib != 4'b0000) on_cnt[c]++;
      pat_or[c] = pat_or[c] | nib;
    end
  endtask

  // Leaves the counter at all-ones so the next period starts on a tick edge.
  task automatic align();
    repeat (Period - 1) step();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    sw = v.sw;
    en = v.en;
    for (int c = 0; c < 2; c++) begin
      on_cnt[c] = 0;
      pat_or[c] = 4'b0000;
    end
    repeat (Period) step();
    chk($sformatf("vec%0d_on0", idx), 32'(on_cnt[0]), 32'(v.on0));
    chk($sformatf("vec%0d_on1", idx), 32'(on_cnt[1]), 32'(v.on1));
    chk($sformatf("vec%0d_pat0", idx), 32'(pat_or[0]), 32'(v.pat0));
    chk($sformatf("vec%0d_pat1", idx), 32'(pat_or[1]), 32'(v.pat1));
  endtask

  task automatic add(input logic [15:0] s, input logic e, input int o0, input int o1,
                     input logic [3:0] p0, input logic [3:0] p1);
    vec_t v;
    v.sw = s; v.en = e; v.on0 = o0; v.on1 = o1; v.pat0 = p0; v.pat1 = p1;
    vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // sw = {ch1, ch0}; one vector per PWM period.
    add(16'h0004, 1'b1,  64,  0, 4'b0110, 4'b0000);  // ramp up 64, 128
    add(16'h0004, 1'b1, 128,  0, 4'b0110, 4'b0000);
    add(16'h0004, 1'b1, 128,  0, 4'b0110, 4'b0000);
    add(16'h0005, 1'b1,  64,  0, 4'b0110, 4'b0000);  // two speed bits -> 0
    add(16'h0005, 1'b1,   0,  0, 4'b0000, 4'b0000);
    add(16'h0005, 1'b1,   0,  0, 4'b0000, 4'b0000);
    add(16'h0004, 1'b1,  64,  0, 4'b0110, 4'b0000);
    add(16'h0004, 1'b1, 128,  0, 4'b0110, 4'b0000);
    add(16'h0084, 1'b1, 128,  0, 4'b0110, 4'b0000);  // reversal: drain, dead
    add(16'h0084, 1'b1,  64,  0, 4'b0110, 4'b0000);
    add(16'h0084, 1'b1,   0,  0, 4'b0000, 4'b0000);
    add(16'h0084, 1'b1,  64,  0, 4'b1001, 4'b0000);
    add(16'h0084, 1'b1, 128,  0, 4'b1001, 4'b0000);
    add(16'h8080, 1'b1,  64,  0, 4'b1001, 4'b0000);  // ch1 flips at zero duty
    add(16'h8080, 1'b1,   0,  0, 4'b0000, 4'b0000);
    add(16'h8000, 1'b1,   0,  0, 4'b0000, 4'b0000);
    add(16'h8140, 1'b1,  64, 64, 4'b0110, 4'b1001);  // independent channels
    add(16'h8140, 1'b1, 128, 76, 4'b0110, 4'b1001);
    add(16'h8140, 1'b1, 192, 76, 4'b0110, 4'b1001);
    add(16'h8140, 1'b1, 230, 76, 4'b0110, 4'b1001);
    add(16'h8140, 1'b1, 230, 76, 4'b0110, 4'b1001);
    add(16'h8104, 1'b1, 166, 76, 4'b0110, 4'b1001);  // ramp down, gated period
    add(16'h8104, 1'b0,   0,  0, 4'b0000, 4'b0000);
    add(16'h8104, 1'b1, 128, 76, 4'b0110, 4'b1001);
    add(16'h8184, 1'b1, 128, 76, 4'b0110, 4'b1001);  // ch0 drains before reset
    add(16'h8184, 1'b1,  64, 76, 4'b0110, 4'b1001);
    add(16'h8104, 1'b1,  64, 64, 4'b0110, 4'b1001);  // after mid-dead reset
    add(16'h8104, 1'b1, 128, 76, 4'b0110, 4'b1001);

    // Reset state, with a nonzero command present.
    reset_in_n = 1'b0;
    en         = 1'b1;
    sw         = 16'h8404;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_bridge", 32'(bridge), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_tick", 32'(period_tick), 32'h0);
    sw = 16'h0000;
    #2 reset_in_n = 1'b1;

    align();
    for (int i = 0; i < 26; i++) run_vec(vecs[i], i);

    // ch0 enters dead time two edges into this period; ch1 is driving.
    sw = 16'h8184;
    en = 1'b1;
    step();
    step();
    chk("pre_reset_ch1", 32'(bridge[7:4]), 32'(4'b1001));
    chk("pre_reset_busy0", 32'(busy[0]), 32'h1);
    #1 reset_in_n = 1'b0;
    #1;
    chk("mid_reset_bridge", 32'(bridge), 32'h0);
    chk("mid_reset_busy", 32'(busy), 32'h0);
    chk("mid_reset_tick", 32'(period_tick), 32'h0);
    #1 reset_in_n = 1'b1;
    model_reset();
    sw = 16'h8104;
    align();
    for (int i = 26; i < 28; i++) run_vec(vecs[i], i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
